// File: rtl/jtpopeye_bck_sched.sv
// Popeye background RAM scheduler: CPU write FIFO issued in free pixel slots.
// Define JTPOPEYE_BCK_CLR_EN to build the full-RAM clear engine.
module jtpopeye_bck_sched #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pxl_cen,
  input  logic        cpu_cen,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [3:0]  cpu_din,
  input  logic [1:0]  vid_slot,
  input  logic [11:0] vid_addr,
  input  logic        clr_req,
  output logic        cpu_wait,
  output logic        ovf,
  output logic [4:0]  fifo_level,
  output logic        clr_busy,
  output logic [11:0] ram_addr,
  output logic [3:0]  ram_din,
  output logic        ram_we_lsb,
  output logic        ram_we_msb
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RECOV = 2'd2;

  logic [16:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   lvl, lvl_nx;
  logic [1:0]    st;
  logic [16:0]   head;
  logic          we_l, push, push_ok, pop;
  logic          free, full, empty;
  logic          clr_go, clr_msb;
  logic [11:0]   clr_addr;

  assign free  = (vid_slot == 2'b00) | (vid_slot == 2'b01);
  assign full  = lvl == FULL;
  assign empty = lvl == '0;
  assign push  = cpu_cen & cpu_we & ~we_l;
  assign pop   = pxl_cen & free & ~empty & (st == IDLE);
  assign push_ok = push & (~full | pop);
  assign head  = mem[rd_ptr];
  assign fifo_level = 5'(lvl);

  always_comb begin
    lvl_nx = lvl;
    if (push_ok & ~pop) lvl_nx = lvl + 1'b1;
    else if (pop & ~push_ok) lvl_nx = lvl - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {cpu_addr, cpu_din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_l     <= 1'b0;
      ovf      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lvl      <= '0;
      cpu_wait <= 1'b0;
    end else begin
      if (cpu_cen) we_l <= cpu_we;
      if (push & ~push_ok) ovf <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      lvl      <= lvl_nx;
      cpu_wait <= lvl_nx == FULL;
    end
  end

  // Non-issue periods always mirror the video fetch address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_we_lsb <= 1'b0;
      ram_we_msb <= 1'b0;
    end else if (pxl_cen) begin
      ram_addr   <= vid_addr;
      ram_we_lsb <= 1'b0;
      ram_we_msb <= 1'b0;
      unique case (1'b1)
        pop: begin
          st         <= ISSUE;
          ram_addr   <= head[15:4];
          ram_din    <= head[3:0];
          ram_we_msb <= head[16];
          ram_we_lsb <= ~head[16];
        end
        clr_go: begin
          st         <= ISSUE;
          ram_addr   <= clr_addr;
          ram_din    <= 4'h0;
          ram_we_msb <= clr_msb;
          ram_we_lsb <= ~clr_msb;
        end
        st == ISSUE: st <= RECOV;
        default:     st <= IDLE;
      endcase
    end
  end

`ifdef JTPOPEYE_BCK_CLR_EN
  logic [12:0] cnt;
  logic        clr_l, clr_iss;

  assign clr_go   = pxl_cen & free & empty & (st == IDLE) & clr_busy;
  assign clr_addr = cnt[11:0];
  assign clr_msb  = cnt[12];

  // A new request overrides any increment landing in the same clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      clr_l    <= 1'b0;
      clr_iss  <= 1'b0;
      clr_busy <= 1'b0;
    end else begin
      clr_l <= clr_req;
      if (pxl_cen) clr_iss <= clr_go;
      if (pxl_cen && st == ISSUE && clr_iss) begin
        cnt <= cnt + 1'b1;
        if (&cnt) clr_busy <= 1'b0;
      end
      if (clr_req & ~clr_l) begin
        clr_busy <= 1'b1;
        cnt      <= '0;
      end
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_req;
  assign clr_go   = 1'b0;
  assign clr_addr = '0;
  assign clr_msb  = 1'b0;
  assign clr_busy = 1'b0;
`endif

endmodule

// File: tb/tb_jtpopeye_bck_sched.sv
// Bench for jtpopeye_bck_sched: queue-based reference model, directed + random.
// Clear engine checks are built when JTPOPEYE_BCK_CLR_EN is defined.
module tb_jtpopeye_bck_sched;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pxl_cen = 1'b0;
  logic        cpu_cen = 1'b0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [3:0]  cpu_din = '0;
  logic [1:0]  vid_slot = '0;
  logic [11:0] vid_addr = '0;
  logic        clr_req = 1'b0;
  logic        cpu_wait, ovf, clr_busy;
  logic [4:0]  fifo_level;
  logic [11:0] ram_addr;
  logic [3:0]  ram_din;
  logic        ram_we_lsb, ram_we_msb;

  jtpopeye_bck_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .pxl_cen(pxl_cen), .cpu_cen(cpu_cen),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .vid_slot(vid_slot),
    .vid_addr(vid_addr), .clr_req(clr_req),
    .cpu_wait(cpu_wait), .ovf(ovf),
    .fifo_level(fifo_level), .clr_busy(clr_busy),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we_lsb(ram_we_lsb), .ram_we_msb(ram_we_msb)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic [16:0] q[$];
  bit          ovf_m, we_prev, clr_prev, clr_m, inc_pend;
  int          cool;
  logic [12:0] ccnt;
  int          wr_seen, clr_seen;
  logic [11:0] e_addr;
  logic [3:0]  e_din;
  logic        e_lsb, e_msb;
  bit          e_wr;
  logic [7:0]  hcnt;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m = 0; we_prev = 0; clr_prev = 0;
    clr_m = 0; inc_pend = 0; cool = 0;
    ccnt = '0;
    e_addr = '0; e_lsb = 0; e_msb = 0;
    e_din = '0; e_wr = 0;
  endtask

  // One clk: apply enables, step model at the edge, check #1 after.
  task automatic tick(input bit pc, input bit cc);
    bit          pop_m, clr_go_m, push_m, free_m;
    logic [16:0] h;
    logic [1:0]  sl;
    logic [11:0] va;
    pxl_cen = pc;
    cpu_cen = cc;
    sl = vid_slot;
    va = vid_addr;
    @(posedge clk);
    free_m   = sl < 2'd2;
    pop_m    = pc && free_m && cool == 0 && q.size() > 0;
    clr_go_m = pc && free_m && cool == 0 &&
               q.size() == 0 && clr_m;
    push_m   = cc && cpu_we && !we_prev;
    if (cc) we_prev = cpu_we;
    e_wr = 0;
    if (pc) begin
      e_lsb = 0; e_msb = 0; e_addr = va;
    end
    if (pc && inc_pend) begin
      if (ccnt == 13'h1FFF) clr_m = 0;
      ccnt++;
      inc_pend = 0;
    end
    if (pop_m) begin
      h = q.pop_front();
      e_addr = h[15:4]; e_din = h[3:0];
      e_msb = h[16]; e_lsb = !h[16];
      e_wr = 1; cool = 2;
    end else if (clr_go_m) begin
      e_addr = ccnt[11:0]; e_din = '0;
      e_msb = ccnt[12]; e_lsb = !ccnt[12];
      e_wr = 1; cool = 2;
      inc_pend = 1; clr_seen++;
    end else if (pc && cool > 0) begin
      cool--;
    end
    if (push_m) begin
      if (q.size() < DEPTH) q.push_back({cpu_addr, cpu_din});
      else ovf_m = 1;
    end
`ifdef JTPOPEYE_BCK_CLR_EN
    if (clr_req && !clr_prev) begin
      clr_m = 1; ccnt = '0;
    end
`endif
    clr_prev = clr_req;
    #1;
    chk("we_lsb", ram_we_lsb, e_lsb);
    chk("we_msb", ram_we_msb, e_msb);
    chk("ram_addr", ram_addr, e_addr);
    if (e_wr) begin
      chk("ram_din", ram_din, e_din);
      wr_seen++;
    end
    chk("fifo_level", fifo_level, q.size());
    chk("cpu_wait", cpu_wait, q.size() == DEPTH);
    chk("ovf", ovf, ovf_m);
    chk("clr_busy", clr_busy, clr_m);
    if (pc) begin
      hcnt++;
      vid_slot = hcnt[1:0];
      vid_addr = 12'($urandom);
    end
    pxl_cen = 0;
    cpu_cen = 0;
  endtask

  task automatic wr(input logic [12:0] a, input logic [3:0] d);
    cpu_we = 1; cpu_addr = a; cpu_din = d;
    tick(0, 1);
    cpu_we = 0;
    tick(0, 1);
  endtask

  task automatic run(input int n);
    repeat (n) tick(1, 0);
  endtask

  initial begin
    int w0, k;
    bit found;
    model_reset();
    hcnt = '0;
    wr_seen = 0;
    clr_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wait", cpu_wait, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_clr", clr_busy, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_we", {ram_we_msb, ram_we_lsb}, 0);
    rst_n = 1;
    run(4);

    // Single LSB write
    wr(13'h0123, 4'hA);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick(1, 0);
      found = e_wr;
    end
    chk("single_seen", found, 1);
    chk("single_lsb", ram_we_lsb, 1);
    chk("single_addr", ram_addr, 12'h123);
    chk("single_din", ram_din, 4'hA);
    run(8);

    // Push at slot 11 with idle FIFO; MSB nibble
    k = 0;
    while (vid_slot != 2'b11 && k < 4) begin
      tick(1, 0); k++;
    end
    cpu_we = 1; cpu_addr = 13'h1FFF; cpu_din = 4'h5;
    tick(1, 1);
    chk("lat_no_we", ram_we_msb, 0);
    cpu_we = 0;
    tick(1, 1);
    chk("lat_msb", ram_we_msb, 1);
    chk("lat_lsb", ram_we_lsb, 0);
    chk("lat_addr", ram_addr, 12'hFFF);
    run(8);

    // Slot guard: fill then drain
    for (int i = 0; i < 4; i++)
      wr(13'($urandom), 4'($urandom));
    chk("sg_wait", cpu_wait, 1);
    chk("sg_level", fifo_level, 4);
    w0 = wr_seen;
    run(24);
    chk("sg_drained", wr_seen - w0, 4);
    chk("sg_level0", fifo_level, 0);

    // Overflow
    for (int i = 0; i < 5; i++)
      wr(13'($urandom), 4'($urandom));
    chk("ovf_set", ovf, 1);
    chk("ovf_level", fifo_level, 4);
    w0 = wr_seen;
    run(24);
    chk("ovf_drained", wr_seen - w0, 4);

    // Reset while WE high
    wr(13'h0456, 4'h3);
    wr(13'h0789, 4'h4);
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick(1, 0);
      found = ram_we_lsb | ram_we_msb;
    end
    chk("rwe_seen", found, 1);
    rst_n = 0;
    #1;
    chk("rwe_lsb", ram_we_lsb, 0);
    chk("rwe_msb", ram_we_msb, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
    chk("rwe_level", fifo_level, 0);
    chk("rwe_ovf", ovf, 0);
    run(8);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(2) == 0) cpu_we = !cpu_we;
      cpu_addr = 13'($urandom);
      cpu_din  = 4'($urandom);
      clr_req  = ($urandom_range(199) == 0);
      tick($urandom_range(3) != 0, $urandom_range(1) == 1);
    end
    clr_req = 0;
    cpu_we = 0;
    tick(1, 1);
    run(30);
    chk("rnd_level0", fifo_level, 0);

`ifdef JTPOPEYE_BCK_CLR_EN
    // Full clear behind one queued CPU write
    wr(13'h0ABC, 4'h7);
    clr_req = 1;
    tick(0, 0);
    clr_req = 0;
    tick(0, 0);
    chk("clr_start", clr_busy, 1);
    w0 = clr_seen;
    found = 0;
    k = 0;
    while ((clr_m || cool > 0) && k < 40000) begin
      tick(1, 0);
      k++;
      if (e_wr && !found) begin
        found = 1;
        chk("clr_cpu_first", ram_addr, 12'hABC);
        chk("clr_cpu_din", ram_din, 4'h7);
      end
    end
    chk("clr_timeout", k < 40000, 1);
    chk("clr_count", clr_seen - w0, 8192);
    chk("clr_done", clr_busy, 0);
`else
    clr_req = 1;
    tick(1, 0);
    clr_req = 0;
    run(8);
    chk("clr_ignored", clr_busy, 0);
    chk("clr_nowr", ram_we_lsb | ram_we_msb, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/jtpopeye_bck_sched.md
# jtpopeye_bck_sched

Background-RAM port scheduler for the Popeye video board. It sits between the CPU background write path and the two 4-bit background RAMs (MSB/LSB nibble halves, 4096 words each). CPU writes go into a small FIFO and are issued only in the pixel slots the video fetch does not use. An optional clear engine zeroes the whole RAM through the same free slots.

## Interface
- `DEPTH`, 4: CPU write FIFO depth; power of two, 2..16.
- `clk` in 1: system clock.
- `rst_n` in 1: reset; asynchronous assert, active-low.
- `pxl_cen` in 1: pixel clock enable; all scheduling advances on it.
- `cpu_cen` in 1: CPU clock enable; write strobe is sampled on it.
- `cpu_we` in 1: CPU background write strobe (level, active-high).
- `cpu_addr` in 13: bit 12 = nibble select (0 → LSB RAM, 1 → MSB RAM), bits 11:0 = word address.
- `cpu_din` in 4: write data.
- `vid_slot` in 2: horizontal pixel phase (low two bits of the H counter).
- `vid_addr` in 12: video fetch address `{V[6:1],H[7:2]}`.
- `clr_req` in 1: start full-RAM clear (pulse, used only with the macro).
- `cpu_wait` out 1: FIFO full.
- `ovf` out 1: sticky, set when a write is dropped.
- `fifo_level` out 5: entries held, 0..DEPTH.
- `clr_busy` out 1: clear engine active.
- `ram_addr` out 12, `ram_din` out 4, `ram_we_lsb` out 1, `ram_we_msb` out 1: RAM port.

## Operation
- Push: on `cpu_cen`, a rising edge of `cpu_we` (compared against its value at the previous `cpu_cen`) pushes `{cpu_addr,cpu_din}`. If the FIFO is full and no pop happens in the same clk, the write is dropped, `ovf` is set, and the FIFO is unchanged.
- Slots: `vid_slot` 2'b10 and 2'b11 are video slots. `ram_addr`=`vid_addr`, both WE low. Slots 2'b00 and 2'b01 are free slots.
- Write FSM states: IDLE, ISSUE, RECOV. Transitions happen on `pxl_cen` only.
  - IDLE → ISSUE: free slot and FIFO non-empty. The head entry is popped, address/data are driven, and exactly one WE goes high for that `pxl_cen` period.
  - ISSUE → RECOV: always. WE goes low and the address returns to the video/idle source.
  - RECOV → IDLE: always.
- Throughput: at most one write per 4-pixel group. A write issued in slot 01 has its RECOV fall in video slot 10, which is harmless.
- Priority in free slots: CPU FIFO over clear engine.
- Idle free slot: `ram_addr`=`vid_addr`, WE low.
- Simultaneous push and pop when full: both happen, and the level stays at DEPTH.
- Pointers wrap modulo DEPTH. `fifo_level` is computed with one extra bit.

## Timing
- Reset values: `cpu_wait`=0, `ovf`=0, `fifo_level`=0, `clr_busy`=0, `ram_addr`=0, `ram_din`=0, both WE=0. FSM goes to IDLE and the FIFO is flushed.
- Reset mid-write: WE drops immediately (asynchronous) and the in-flight entry is lost.
- All outputs are registered on clk. Port outputs update only on `pxl_cen` clk edges.
- `cpu_wait` and `fifo_level` update in the clk after the push or pop.
- Latency, empty FIFO, push arriving in slot 11: WE asserts at the next slot 00 `pxl_cen`. Worst case is 4 `pxl_cen` plus queue depth × 4.

## Configuration
- `JTPOPEYE_BCK_CLR_EN` defined:
  - A `clr_req` rising edge (clk domain) sets `clr_busy` and zeroes a 13-bit counter.
  - Each free slot not taken by the CPU runs ISSUE/RECOV with `ram_addr`=cnt[11:0], `ram_din`=0, and WE selected by cnt[12].
  - The counter increments after each ISSUE. `clr_busy` drops after count 8191 is written.
  - `clr_req` while busy restarts the count at 0.
- Not defined: `clr_req` is ignored, `clr_busy` is tied to 0, and no clear logic is synthesised.

## Test plan
- Single write: `cpu_addr`=13'h0123, `cpu_din`=4'hA, FIFO empty → one `pxl_cen` with `ram_we_lsb`=1, `ram_addr`=12'h123, `ram_din`=A, in slot 00 or 01 only.
- Nibble select: `cpu_addr`=13'h1FFF, `cpu_din`=5 → `ram_we_msb`=1 and `ram_we_lsb`=0; `ram_addr`=12'hFFF.
- Slot guard: 4 back-to-back writes with DEPTH=4 → `cpu_wait`=1 after the 4th; no WE is ever high in slots 10/11; drains at one write per 4 pixels; `fifo_level` 4→0.
- Overflow: 5 writes with no `pxl_cen` → `ovf`=1, `fifo_level`=4, and only the first 4 appear on the port.
- Reset during ISSUE: `rst_n` low while WE is high → WE=0 the same cycle; after release `fifo_level`=0 and `ovf`=0.
- Clear (macro on): `clr_req` pulse with a CPU write queued → the CPU write is issued first; then 8192 zero writes covering both nibbles; `clr_busy` falls after address 12'hFFF of the MSB half is written.
